// File: rtl/bcd_ctrl_pkg.sv
// Shared state encoding and BCD constants for the stopwatch count controller.
package bcd_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_OVF   = 2'd3
   } ctrl_state_t;

   localparam logic [11:0] BCD_MAX  = 12'h999;
   localparam logic [11:0] BCD_ZERO = 12'h000;

endpackage

// File: rtl/bcd_tick_gen.sv
// Prescaler that issues a registered one-cycle tick every DIV enabled cycles.
// A disabled prescaler holds its residual count so a resume continues the period.
module bcd_tick_gen #(
   parameter int DIV = 50000
) (
   input  logic Clk,
   input  logic Rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] psc;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         psc  <= '0;
         tick <= 1'b0;
      end else if (clr) begin
         psc  <= '0;
         tick <= 1'b0;
      end else if (en) begin
         tick <= (psc == LAST);
         psc  <= (psc == LAST) ? '0 : psc + PW'(1);
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear sequencer for a 3-digit BCD stopwatch counter chain.
//   state    | meaning
//   ST_IDLE  | stopped, prescaler zero
//   ST_RUN   | prescaler running, count ticks issued
//   ST_PAUSE | prescaler frozen at its residual value
//   ST_OVF   | counter wrapped past 999, halted until Clear
module bcd_count_ctrl
   import bcd_ctrl_pkg::*;
#(
   parameter int DIV = 50000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic        Stop,
   input  logic        Clear,
   input  logic        Lap,
   input  logic [11:0] Cnt_Q,
   input  logic        Cnt_Cout,
   output logic        Cnt_Cin,
   output logic        Cnt_Clr,
   output logic [11:0] Disp_Q,
   output logic        Running,
   output logic        Ovf
);

   ctrl_state_t state, state_nxt;
   logic        ovf_evt;
   logic        cmd_start;
   logic        cmd_lap;
   logic        tick_en;
   logic        lap_hold;
   logic        counting;

   // Only the highest-priority pulse of a cycle is acted on.
   assign ovf_evt   = Cnt_Cin && Cnt_Cout;
   assign cmd_start = Start && !Stop;
   assign cmd_lap   = Lap && !Start && !Stop;
   assign counting  = (state == ST_RUN) || (state == ST_PAUSE);

   always_comb begin
      state_nxt = state;
      if (Clear) begin
         state_nxt = ST_IDLE;
      end else if (ovf_evt) begin
         state_nxt = ST_OVF;
      end else begin
         case (state)
            ST_IDLE, ST_PAUSE: if (cmd_start) state_nxt = ST_RUN;
            ST_RUN:            if (Stop)      state_nxt = ST_PAUSE;
            default:           state_nxt = state;
         endcase
      end
   end

   // Prescaler only advances on edges that keep us in RUN, so a tick
   // can never land after Stop, Clear or overflow.
   assign tick_en = (state == ST_RUN) && (state_nxt == ST_RUN);

   bcd_tick_gen #(.DIV(DIV)) u_tick_gen (
      .Clk  (Clk),
      .Rst  (Rst),
      .en   (tick_en),
      .clr  (Clear),
      .tick (Cnt_Cin)
   );

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state    <= ST_IDLE;
         lap_hold <= 1'b0;
         Disp_Q   <= BCD_ZERO;
         Cnt_Clr  <= 1'b0;
      end else begin
         state   <= state_nxt;
         Cnt_Clr <= Clear;
         if (Clear) begin
            lap_hold <= 1'b0;
            Disp_Q   <= BCD_ZERO;
         end else if (ovf_evt) begin
            lap_hold <= 1'b0;
            Disp_Q   <= BCD_MAX;
         end else begin
            if (cmd_lap && counting) lap_hold <= !lap_hold;
            if (!lap_hold && counting) Disp_Q <= Cnt_Q;
         end
      end
   end

   assign Running = (state == ST_RUN);
   assign Ovf     = (state == ST_OVF);

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: two instances (DIV=4 and DIV=1) share the command
// inputs, each driving its own behavioural BCD counter, checked against a model.
module tb_bcd_count_ctrl;

   localparam int DIV_A = 4;
   localparam int DIV_B = 1;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_OVF   = 3;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Start, Stop, Clear, Lap;
   logic [11:0] cnt_q    [2];
   logic        cnt_cout [2];
   logic        cnt_cin  [2];
   logic        cnt_clr  [2];
   logic [11:0] disp_q   [2];
   logic        running  [2];
   logic        ovf      [2];

   int    env_cnt [2];
   int    m_mode  [2];
   int    m_age   [2];
   int    m_disp  [2];
   logic  m_cin   [2];
   logic  m_clr   [2];
   logic  m_hold  [2];
   int    n_chk = 0;
   int    n_pass = 0;
   string phase = "reset";

   always #5 Clk = ~Clk;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int div_of(input int k);
      return (k == 0) ? DIV_A : DIV_B;
   endfunction

   assign cnt_q[0]    = to_bcd(env_cnt[0]);
   assign cnt_q[1]    = to_bcd(env_cnt[1]);
   assign cnt_cout[0] = cnt_cin[0] && (env_cnt[0] == 999);
   assign cnt_cout[1] = cnt_cin[1] && (env_cnt[1] == 999);

   bcd_count_ctrl #(.DIV(DIV_A)) u_dut_a (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .Clear(Clear), .Lap(Lap),
      .Cnt_Q(cnt_q[0]), .Cnt_Cout(cnt_cout[0]), .Cnt_Cin(cnt_cin[0]), .Cnt_Clr(cnt_clr[0]),
      .Disp_Q(disp_q[0]), .Running(running[0]), .Ovf(ovf[0])
   );

   bcd_count_ctrl #(.DIV(DIV_B)) u_dut_b (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .Clear(Clear), .Lap(Lap),
      .Cnt_Q(cnt_q[1]), .Cnt_Cout(cnt_cout[1]), .Cnt_Cin(cnt_cin[1]), .Cnt_Clr(cnt_clr[1]),
      .Disp_Q(disp_q[1]), .Running(running[1]), .Ovf(ovf[1])
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s d%0d cin", phase, k), int'(cnt_cin[k]), int'(m_cin[k]));
         check($sformatf("%s d%0d clr", phase, k), int'(cnt_clr[k]), int'(m_clr[k]));
         check($sformatf("%s d%0d disp", phase, k), int'(disp_q[k]), int'(to_bcd(m_disp[k])));
         check($sformatf("%s d%0d running", phase, k), int'(running[k]), int'(m_mode[k] == M_RUN));
         check($sformatf("%s d%0d ovf", phase, k), int'(ovf[k]), int'(m_mode[k] == M_OVF));
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = M_IDLE;
         m_age[k]  = 0;
         m_disp[k] = 0;
         m_cin[k]  = 1'b0;
         m_clr[k]  = 1'b0;
         m_hold[k] = 1'b0;
      end
   endtask

   // One clock edge of the stopwatch, from its behavioural rules; q is the
   // counter value the controller saw before the edge.
   task automatic model_edge(input int k, input logic st, input logic sp,
                             input logic cl, input logic lp, input int q);
      int   nmode;
      logic active;
      active   = (m_mode[k] == M_RUN) || (m_mode[k] == M_PAUSE);
      m_clr[k] = cl;
      if (cl) begin
         m_mode[k] = M_IDLE;
         m_age[k]  = 0;
         m_cin[k]  = 1'b0;
         m_disp[k] = 0;
         m_hold[k] = 1'b0;
      end else if (m_cin[k] && q == 999) begin
         m_mode[k] = M_OVF;
         m_cin[k]  = 1'b0;
         m_disp[k] = 999;
         m_hold[k] = 1'b0;
      end else begin
         if (!m_hold[k] && active) m_disp[k] = q;
         nmode = m_mode[k];
         if (sp) begin
            if (m_mode[k] == M_RUN) nmode = M_PAUSE;
         end else if (st) begin
            if (m_mode[k] == M_IDLE || m_mode[k] == M_PAUSE) nmode = M_RUN;
         end else if (lp) begin
            if (active) m_hold[k] = !m_hold[k];
         end
         if (m_mode[k] == M_RUN && nmode == M_RUN) begin
            m_age[k]++;
            m_cin[k] = ((m_age[k] % div_of(k)) == 0);
         end else begin
            m_cin[k] = 1'b0;
         end
         m_mode[k] = nmode;
      end
   endtask

   task automatic step(input logic st, input logic sp, input logic cl, input logic lp);
      logic pc_cin [2];
      logic pc_clr [2];
      int   pq     [2];
      Start = st; Stop = sp; Clear = cl; Lap = lp;
      @(negedge Clk);
      for (int k = 0; k < 2; k++) begin
         pc_cin[k] = cnt_cin[k];
         pc_clr[k] = cnt_clr[k];
         pq[k]     = env_cnt[k];
      end
      @(posedge Clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         model_edge(k, st, sp, cl, lp, pq[k]);
         if (pc_clr[k]) env_cnt[k] = 0;
         else if (pc_cin[k]) env_cnt[k] = (env_cnt[k] + 1) % 1000;
      end
      Start = 1'b0; Stop = 1'b0; Clear = 1'b0; Lap = 1'b0;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int budget;
      int r;
      Rst = 1'b1;
      Start = 1'b0; Stop = 1'b0; Clear = 1'b0; Lap = 1'b0;
      env_cnt[0] = 0;
      env_cnt[1] = 0;
      model_reset();
      repeat (3) @(posedge Clk);
      #1;
      check_all();
      #2 Rst = 1'b0;

      phase = "first_tick";
      idle(6);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(12);

      phase = "pause";
      budget = 0;
      while (!(m_disp[0] == 5 && (m_age[0] % DIV_A) == 2) && budget < 100) begin
         idle(1);
         budget++;
      end
      check("pause point reached", int'(budget < 100), 1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(20);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(10);
      check("resume disp past 5", int'(disp_q[0] >= 12'h006), 1);

      phase = "lap";
      budget = 0;
      while (m_disp[0] != 12 && budget < 200) begin
         idle(1);
         budget++;
      end
      check("lap point reached", int'(budget < 200), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      budget = 0;
      while (env_cnt[0] != 20 && budget < 200) begin
         idle(1);
         budget++;
      end
      check("lap count reached", int'(budget < 200), 1);
      check("lap frozen disp", int'(disp_q[0]), 'h012);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      check("lap released disp", int'(disp_q[0]), int'(cnt_q[0]));

      phase = "clear_start";
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("clear pulse", int'(cnt_clr[0]), 1);
      check("clear disp", int'(disp_q[0]), 0);
      idle(1);
      check("clear pulse width", int'(cnt_clr[0]), 0);
      idle(6);

      phase = "async_reset";
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(9);
      #1 Rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #1 Rst = 1'b0;
      idle(10);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(5);

      phase = "overflow";
      budget = 0;
      while (!(m_mode[0] == M_OVF && m_mode[1] == M_OVF) && budget < 6000) begin
         idle(1);
         budget++;
      end
      check("overflow reached", int'(budget < 6000), 1);
      check("overflow disp", int'(disp_q[0]), 'h999);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      check("overflow sticky", int'(ovf[1]), 1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);

      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         step(r < 4, r >= 4 && r < 7, r == 7, r >= 8 && r < 11);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Run/pause/clear controller that sequences the 3-digit cascaded BCD counter (000-999) as a stopwatch.
- A prescaler generates the counter's count-enable (Cin); a command FSM starts, pauses and clears counting.
- Overflow is detected from the counter's carry-out; the display value is latched with lap-hold support.
- Sits between the push-button/command logic and the BCD counter chain; drives the display path.

Parameters:
DIV, 50000, Clk cycles per count tick (1 kHz at 50 MHz); legal range >= 1.
PW, $clog2(DIV), prescaler width; derived, not overridden.

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-high reset
Start  input  1  single-cycle pulse: begin or resume counting
Stop  input  1  single-cycle pulse: pause counting
Clear  input  1  single-cycle pulse: zero everything, return to idle
Lap  input  1  single-cycle pulse: toggle display freeze
Cnt_Q  input  12  BCD value from the counter chain {hundreds, tens, units}
Cnt_Cout  input  1  counter chain carry-out; combinational, equals Cnt_Cin && Cnt_Q==12'h999
Cnt_Cin  output  1  registered count enable to the counter chain
Cnt_Clr  output  1  registered one-cycle synchronous clear request to the counter chain
Disp_Q  output  12  latched BCD value for the display
Running  output  1  high in RUN
Ovf  output  1  sticky overflow flag

Behaviour:
- Reset (async, Rst=1):
  - State IDLE; prescaler 0; lap_hold 0.
  - Outputs Cnt_Cin=0, Cnt_Clr=0, Disp_Q=12'h000, Running=0, Ovf=0.
- States:
  - IDLE: counter stopped, prescaler 0.
  - RUN: prescaler runs, Cin ticks are issued.
  - PAUSE: prescaler frozen at its residual value.
  - OVF: counting halted.
- Command priority when pulses coincide in one cycle: Clear > Stop > Start > Lap.
- Transitions:
  - IDLE -Start-> RUN.
  - RUN -Stop-> PAUSE.
  - PAUSE -Start-> RUN, resuming from the residual prescaler value (no tick restart).
  - RUN -overflow-> OVF.
  - Any state -Clear-> IDLE.
  - Start in RUN or OVF is ignored. Stop outside RUN is ignored.
- Clear:
  - Next cycle: state IDLE, prescaler 0, Ovf 0, lap_hold 0, Disp_Q 12'h000.
  - Cnt_Clr is high for exactly one cycle; Cnt_Cin is forced 0 that cycle.
- Prescaler:
  - In RUN it counts 0..DIV-1 and wraps.
  - Cnt_Cin is registered high for exactly one cycle, the cycle after the prescaler equals DIV-1.
  - First Cnt_Cin occurs DIV cycles after the Start pulse is sampled. Period is DIV cycles.
  - DIV=1: Cnt_Cin is high every cycle while in RUN.
- Cnt_Cin already asserted when Stop is sampled: that increment completes; no further Cin is issued.
- Overflow:
  - In any cycle with Cnt_Cin=1 and Cnt_Cout=1: next state OVF, Ovf<=1, Disp_Q<=12'h999, lap_hold<=0. The counter itself wraps to 000.
  - If Clear is sampled in the same cycle, Clear wins and Ovf stays 0.
  - If Stop is sampled in the same cycle, OVF wins.
- Display:
  - When lap_hold=0 and state is RUN or PAUSE, Disp_Q<=Cnt_Q every cycle (1-cycle latency).
  - lap_hold=1 freezes Disp_Q while counting continues.
  - Lap toggles lap_hold in RUN and PAUSE only; it is ignored in IDLE and OVF.
  - In OVF, Disp_Q holds 12'h999 until Clear.
- Running = (state==RUN), registered with the state.
- The counter's own reset is independent; Cnt_Clr is the only clear path this block drives.

Decomposition:
- Package bcd_ctrl_pkg:
  - State encoding IDLE/RUN/PAUSE/OVF (2-bit localparams).
  - BCD_MAX = 12'h999; BCD_ZERO = 12'h000.
- Sub-module bcd_tick_gen: prescaler with enable (RUN) and sync clear (Clear); outputs a registered one-cycle tick.
  - Top holds the FSM, lap_hold and the display latch.

Test Plan:
- DIV=4; Start at cycle 10 -> Cnt_Cin high at cycles 14, 18, 22...; with the counter attached, Disp_Q reads 12'h001 one cycle after the first increment.
- DIV=4; run to Disp_Q=12'h005, Stop mid-period (prescaler=2), wait 20 cycles, Start -> Cin stays 0 while paused; first Cin comes 2 cycles after resume; Disp_Q then reaches 12'h006.
- DIV=1; Start and run 1000 ticks -> at the tick with Cnt_Q=12'h999, Cnt_Cout=1 and next cycle Ovf=1, Running=0, Disp_Q=12'h999; Start afterwards is ignored.
- Lap at Disp_Q=12'h012 -> Disp_Q holds 12'h012 while Cnt_Q advances to 12'h020; second Lap -> Disp_Q tracks Cnt_Q again within 1 cycle.
- Clear and Start in the same cycle during RUN -> IDLE, Cnt_Clr one-cycle pulse, Disp_Q=12'h000, Ovf=0, no Cin issued.
- Rst asserted mid-RUN, asynchronously between edges -> all outputs zero immediately; after release, Start is required before any Cnt_Cin appears.
